reg_muldiv_unit: RTL

Multi-cycle unsigned multiply/divide unit that sits downstream of the register file read ports and upstream of its write port. It captures two operands from rd1/rd2 on a start pulse and iterates for N cycles. It then issues a single-cycle write-back (wd3/wa3/we3) straight into the register file write port. It offloads MUL/DIV from the single-cycle ALU path; the control unit stalls on busy.

---
 rtl/reg_muldiv_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/reg_muldiv_unit.sv
// Multi-cycle unsigned multiply/divide unit between the register file read ports and its write port.
// Runs N shift-add or restoring-divide iterations, then issues a single registered write-back.
module reg_muldiv_unit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [4:0]   rd_addr,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic [N-1:0] wd3,
    output logic [4:0]   wa3,
    output logic         we3
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

    state_t         state;
    logic [CW-1:0]  count;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_next;
    logic [N-1:0]   opnd;
    logic [1:0]     op_q;
    logic [4:0]     addr_q;
    logic [N:0]     mul_sum;
    logic [N:0]     div_shift;
    logic [N:0]     div_diff;

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV,
    // so both the high-half and remainder results come from acc[2N-1:N].
    always_comb begin
        mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : {(N+1){1'b0}});
        div_shift = {acc[2*N-1:N], acc[N-1]};
        div_diff  = div_shift - {1'b0, opnd};
        acc_next  = {mul_sum, acc[N-1:1]};
        if (op_q[1]) begin
            if (div_shift >= {1'b0, opnd})
                acc_next = {div_diff[N-1:0], acc[N-2:0], 1'b1};
            else
                acc_next = {div_shift[N-1:0], acc[N-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            op_q     <= '0;
            addr_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            wd3      <= '0;
            wa3      <= '0;
            we3      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    we3  <= 1'b0;
                    if (start) begin
                        opnd     <= op[1] ? b : a;
                        acc      <= {{N{1'b0}}, (op[1] ? a : b)};
                        op_q     <= op;
                        addr_q   <= rd_addr;
                        div_zero <= 1'b0;
                        count    <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    count <= count + CW'(1);
                    if (count == CW'(N - 1)) begin
                        state <= WB;
                        // A zero divisor needs no special datapath: restoring division
                        // naturally yields all-ones quotient and remainder == dividend.
                        if (op_q[1] && opnd == '0)
                            div_zero <= 1'b1;
                    end
                end
                WB: begin
                    wd3   <= op_q[0] ? acc[2*N-1:N] : acc[N-1:0];
                    wa3   <= addr_q;
                    we3   <= (addr_q != 5'd0);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
